// File: rtl/pll_ctrl_pkg.sv
// Shared types and limits for the PLL sequencer: state encoding, divider bundle, legality check.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PROG,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_ERROR
  } pll_state_e;

  localparam int unsigned FBDIV_MIN     = 16;
  localparam int unsigned PD_CYCLES_MIN = 4;

  typedef struct packed {
    logic [5:0]  refdiv;
    logic [11:0] fbdiv;
    logic [2:0]  postdiv1;
    logic [2:0]  postdiv2;
  } pll_cfg_t;

  function automatic logic cfg_legal(input pll_cfg_t c);
    return (c.refdiv != '0) && (c.fbdiv >= 12'(FBDIV_MIN)) &&
           (c.postdiv1 != '0) && (c.postdiv2 != '0) && (c.postdiv1 >= c.postdiv2);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop LOCK synchroniser plus a counter of consecutive synchronised-high cycles.
// lock_stable_o fires combinationally on the cycle the run length reaches LOCK_STABLE.
module pll_lock_sync
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_i,
  input  logic en_i,
  output logic lock_s_o,
  output logic lock_stable_o
);

  localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= lock_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end

  // Any low sample, or leaving the enabled window, restarts the run.
  always_comb begin
    cnt_d = '0;
    if (en_i && s2_q) begin
      cnt_d = (cnt_q == CW'(LOCK_STABLE)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign lock_s_o      = s2_q;
  assign lock_stable_o = en_i && s2_q && (cnt_q >= CW'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_ctrl.sv
// Safe bring-up sequencer for the PLL macro: bypass, power-down, load dividers, power-up, lock, unbypass.
// New pin values appear the cycle after acceptance; cfg_ready drops while busy or while pd_req is high.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter logic [5:0]  DEF_REFDIV   = 6'd1,
  parameter logic [11:0] DEF_FBDIV    = 12'd32,
  parameter logic [2:0]  DEF_POSTDIV1 = 3'd1,
  parameter logic [2:0]  DEF_POSTDIV2 = 3'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [5:0]  cfg_refdiv,
  input  logic [11:0] cfg_fbdiv,
  input  logic [2:0]  cfg_postdiv1,
  input  logic [2:0]  cfg_postdiv2,
  input  logic        pd_req,
  input  logic        pll_lock,
  output logic        pll_pd,
  output logic        pll_bypass,
  output logic        pll_dsmpd,
  output logic        pll_foutpostdivpd,
  output logic        pll_foutvcopd,
  output logic [5:0]  pll_refdiv,
  output logic [11:0] pll_fbdiv,
  output logic [2:0]  pll_postdiv1,
  output logic [2:0]  pll_postdiv2,
  output logic        locked,
  output logic        busy,
  output logic        cfg_err,
  output logic        timeout_err,
  output logic        lock_lost
);

  localparam int unsigned PD_EFF  = (PD_CYCLES < PD_CYCLES_MIN) ? PD_CYCLES_MIN : PD_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > PD_EFF) ? LOCK_TIMEOUT : PD_EFF;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam pll_cfg_t    DEF_CFG = '{refdiv: DEF_REFDIV, fbdiv: DEF_FBDIV,
                                      postdiv1: DEF_POSTDIV1, postdiv2: DEF_POSTDIV2};

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pll_cfg_t      div_q, div_d, req;
  logic          ready_q, ready_d, pd_q, pd_d, byp_q, byp_d, fopd_q, fopd_d;
  logic          locked_q, locked_d, busy_q, busy_d, err_q, err_d;
  logic          tmo_q, tmo_d, lost_q, lost_d;
  logic          hs, legal, take, lock_s, lock_stable;

  assign req       = {cfg_refdiv, cfg_fbdiv, cfg_postdiv1, cfg_postdiv2};
  assign legal     = cfg_legal(req);
  // Power-down wins over a simultaneous handshake, so ready is masked by pd_req directly.
  assign cfg_ready = ready_q & ~pd_req;
  assign hs        = cfg_valid & cfg_ready;
  assign take      = hs & legal;

  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_sync (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock_i        (pll_lock),
    .en_i          (state_q == ST_WAIT_LOCK),
    .lock_s_o      (lock_s),
    .lock_stable_o (lock_stable)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pd_req) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF, ST_ERROR: if (take) state_d = ST_PROG;
        ST_PROG:          if (cnt_q >= CW'(PD_EFF - 1)) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_stable)                            state_d = ST_RUN;
          else if (cnt_q >= CW'(LOCK_TIMEOUT - 1))    state_d = ST_ERROR;
        end
        ST_RUN: begin
          if (take)         state_d = ST_PROG;
          else if (!lock_s) state_d = ST_WAIT_LOCK;
        end
        default:          state_d = ST_OFF;
      endcase
    end

    // One counter serves both PROG hold-off and the lock timeout; any state change restarts it.
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_PROG) || (state_q == ST_WAIT_LOCK))) begin
      cnt_d = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
    end

    pd_d     = (state_d == ST_OFF) || (state_d == ST_PROG) || (state_d == ST_ERROR);
    byp_d    = (state_d != ST_RUN);
    fopd_d   = (state_d != ST_RUN);
    locked_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_PROG) || (state_d == ST_WAIT_LOCK);
    ready_d  = (state_d == ST_OFF) || (state_d == ST_RUN) || (state_d == ST_ERROR);
    err_d    = hs & ~legal;
    div_d    = take ? req : div_q;

    tmo_d  = tmo_q;
    lost_d = lost_q;
    if (take) begin
      tmo_d  = 1'b0;
      lost_d = 1'b0;
    end else begin
      if (state_d == ST_ERROR) tmo_d = 1'b1;
      if ((state_q == ST_RUN) && (state_d == ST_WAIT_LOCK)) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DEF_CFG;
      ready_q  <= 1'b1;
      pd_q     <= 1'b1;
      byp_q    <= 1'b1;
      fopd_q   <= 1'b1;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ready_q  <= ready_d;
      pd_q     <= pd_d;
      byp_q    <= byp_d;
      fopd_q   <= fopd_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      lost_q   <= lost_d;
    end
  end

  // Integer mode only: sigma-delta and VCO-output power-downs stay asserted.
  assign pll_dsmpd         = 1'b1;
  assign pll_foutvcopd     = 1'b1;
  assign pll_pd            = pd_q;
  assign pll_bypass        = byp_q;
  assign pll_foutpostdivpd = fopd_q;
  assign pll_refdiv        = div_q.refdiv;
  assign pll_fbdiv         = div_q.fbdiv;
  assign pll_postdiv1      = div_q.postdiv1;
  assign pll_postdiv2      = div_q.postdiv2;
  assign locked            = locked_q;
  assign busy              = busy_q;
  assign cfg_err           = err_q;
  assign timeout_err       = tmo_q;
  assign lock_lost         = lost_q;

endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
Sequencer that drives the configuration and power-control pins of the TSMC28 PLL macro. It consumes the macro's LOCK output.
- Accepts divider settings through a valid/ready request and validates them.
- Runs the safe sequence: bypass, power-down, load dividers, power-up, wait for lock, release bypass.
- Reports status to the SoC control registers.
- Runs on the reference clock (FREF domain), which is always present.

Parameters:
PD_CYCLES, 8, cycles PD is held high after new dividers are applied (minimum 4).
LOCK_TIMEOUT, 4096, cycles allowed from PD release until stable lock.
LOCK_STABLE, 16, consecutive synchronised-LOCK-high cycles required to declare lock.
DEF_REFDIV, 1, reset value of pll_refdiv.
DEF_FBDIV, 32, reset value of pll_fbdiv.
DEF_POSTDIV1, 1, reset value of pll_postdiv1.
DEF_POSTDIV2, 1, reset value of pll_postdiv2.

Ports:
clk  in  1  reference clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
cfg_valid  in  1  new configuration request.
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
cfg_refdiv  in  6  requested REFDIV.
cfg_fbdiv  in  12  requested FBDIV.
cfg_postdiv1  in  3  requested POSTDIV1.
cfg_postdiv2  in  3  requested POSTDIV2.
pd_req  in  1  level; 1 = keep PLL powered down.
pll_lock  in  1  LOCK from macro; asynchronous to clk.
pll_pd, pll_bypass, pll_dsmpd, pll_foutpostdivpd, pll_foutvcopd  out  1 each  macro controls.
pll_refdiv  out  6  divider to macro.
pll_fbdiv  out  12  divider to macro.
pll_postdiv1  out  3  divider to macro.
pll_postdiv2  out  3  divider to macro.
locked  out  1  1 only in RUN.
busy  out  1  1 in PROG and WAIT_LOCK.
cfg_err  out  1  one-cycle pulse when a request is rejected.
timeout_err  out  1  sticky; cleared by the next accepted request.
lock_lost  out  1  sticky; set on loss of lock in RUN, cleared by the next accepted request.

Behaviour:
- All outputs are registered.
- Reset values:
  - pll_pd = pll_bypass = pll_dsmpd = pll_foutpostdivpd = pll_foutvcopd = 1.
  - Dividers = DEF_* parameters.
  - Status outputs = 0.
  - State = OFF.
- pll_dsmpd and pll_foutvcopd are 1 in every state (integer mode only).
- pll_lock passes through a 2-flop synchroniser; lock_s denotes the synchroniser output.
- Validation rule: a request is legal iff refdiv != 0, fbdiv >= 16, postdiv1 != 0, postdiv2 != 0 and postdiv1 >= postdiv2.
  - Illegal request: cfg_err pulses the cycle after the handshake; state and dividers are unchanged.
- cfg_ready = 1 in OFF (when pd_req = 0), RUN and ERROR; otherwise 0. cfg_ready is 0 whenever pd_req = 1.
- States:
  - OFF: pd = 1, bypass = 1. A legal request goes to PROG.
  - PROG: pd = 1, bypass = 1, foutpostdivpd = 1. Dividers are latched on the cycle after acceptance. The counter runs PD_CYCLES cycles, then the state goes to WAIT_LOCK.
  - WAIT_LOCK: pd = 0, bypass = 1.
    - Timeout counter increments every cycle.
    - Stable counter increments while lock_s = 1 and resets to 0 when lock_s = 0.
    - Stable counter reaching LOCK_STABLE goes to RUN.
    - Timeout counter reaching LOCK_TIMEOUT without that goes to ERROR.
    - If both conditions occur in the same cycle, RUN wins.
  - RUN: pd = 0, bypass = 0, foutpostdivpd = 0, locked = 1.
    - lock_s = 0 for one cycle: set lock_lost, go to WAIT_LOCK with counters cleared. Dividers are kept; bypass reasserts next cycle.
    - A legal request goes to PROG (re-sequence with bypass).
  - ERROR: pd = 1, bypass = 1, timeout_err = 1. A legal request goes to PROG and clears timeout_err and lock_lost.
- Power-down request:
  - pd_req = 1 in any state forces OFF on the next cycle and clears both counters. This has priority over a simultaneous handshake, which is not accepted.
  - Dividers hold their last values in OFF.
- Latency:
  - Acceptance at cycle T gives pll_bypass = 1 and pll_pd = 1 at T+1, and pll_pd = 0 at T+1+PD_CYCLES.
  - locked rises LOCK_STABLE+2 cycles after pll_lock rises, if pll_lock was already high before PD release. The +2 is the synchroniser.
- Counters: the timeout counter is clog2(LOCK_TIMEOUT+1) bits and saturates; it never wraps.
- Reset asserted mid-operation returns to the reset values on the next edge.

Decomposition:
- Package pll_ctrl_pkg:
  - State enum (OFF, PROG, WAIT_LOCK, RUN, ERROR).
  - Validation limits: FBDIV_MIN = 16, PD_CYCLES_MIN = 4.
  - Packed struct pll_cfg_t {refdiv, fbdiv, postdiv1, postdiv2}.
- One sub-module, pll_lock_sync: 2-flop synchroniser plus the consecutive-high stable counter, outputting lock_stable.

Test Plan:
- Reset, pd_req = 0, pll_lock = 0 -> all power-down/bypass outputs = 1, dividers = 1/32/1/1, cfg_ready = 1.
- Request 1/50/2/1 at T, pll_lock rises at T+20 -> pd falls at T+9, locked rises at T+38, bypass = 0 and foutpostdivpd = 0 at T+38.
- Request fbdiv = 8, then postdiv1 = 1 with postdiv2 = 2 -> cfg_err pulses each time, dividers stay at their prior values, state stays at its prior value.
- pll_lock held 0 after a legal request at T -> ERROR at T+9+4096, timeout_err = 1, pd = 1; next legal request clears timeout_err.
- In RUN, drop pll_lock for 3 cycles -> lock_lost = 1, bypass = 1, locked = 0; relock after 16 stable cycles returns to RUN.
- pd_req = 1 during WAIT_LOCK with cfg_valid = 1 in the same cycle -> OFF next cycle, pd = 1, request not accepted, dividers unchanged.
